// File: rtl/dm_arb_pkg.sv
// Shared types and defaults for the dat_mem access arbiter.
package dm_arb_pkg;

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} arb_state_t;

  localparam int unsigned AW_DEF   = 8;
  localparam int unsigned DW_DEF   = 8;
  localparam logic [7:0]  MSG_BASE = 8'd64;

endpackage

// File: rtl/dm_access_arbiter.sv
// Round-robin arbiter sharing one dat_mem between the message loader (port 0)
// and the decrypt engine (port 1), with burst lock and a starvation cap.
module dm_access_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned AW        = AW_DEF,
  parameter int unsigned DW        = DW_DEF,
  parameter int unsigned MAX_BURST = 72
) (
  input  logic          clk,
  input  logic          init_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_raddr,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_data_in,
  input  logic [DW-1:0] mem_data_out
);

  localparam int unsigned     BCW     = $clog2(MAX_BURST) + 1;
  localparam logic [BCW-1:0]  CT_MAX  = BCW'(MAX_BURST);
  localparam logic [BCW-1:0]  CT_LAST = BCW'(MAX_BURST - 1);

  arb_state_t     state, state_nxt;
  logic           prio, prio_nxt;
  logic [BCW-1:0] burst_ct, burst_ct_nxt;
  logic           acc0, acc1;
  logic           cap_hit;

  assign acc0 = gnt0 & req0;
  assign acc1 = gnt1 & req1;

  // >= rather than == so a count that saturated while the other port was
  // quiet still forces a handover once that port starts waiting.
  assign cap_hit = (burst_ct >= CT_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req0 && req1)  state_nxt = prio ? GNT1 : GNT0;
        else if (req0)     state_nxt = GNT0;
        else if (req1)     state_nxt = GNT1;
      end
      GNT0: begin
        if (!req0)                         state_nxt = req1 ? GNT1 : IDLE;
        else if (req1 && (!lock0 || cap_hit)) state_nxt = GNT1;
      end
      GNT1: begin
        if (!req1)                         state_nxt = req0 ? GNT0 : IDLE;
        else if (req0 && (!lock1 || cap_hit)) state_nxt = GNT0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    prio_nxt     = prio;
    burst_ct_nxt = burst_ct;
    if (state_nxt != state) begin
      burst_ct_nxt = '0;
      if (state_nxt == GNT0)      prio_nxt = 1'b1;
      else if (state_nxt == GNT1) prio_nxt = 1'b0;
    end else if ((acc0 || acc1) && (burst_ct != CT_MAX)) begin
      burst_ct_nxt = burst_ct + BCW'(1);
    end
  end

  always_comb begin
    mem_wr_en   = 1'b0;
    mem_raddr   = '0;
    mem_waddr   = '0;
    mem_data_in = '0;
    if (acc0) begin
      mem_wr_en   = we0;
      mem_raddr   = addr0;
      mem_waddr   = addr0;
      mem_data_in = wdata0;
    end else if (acc1) begin
      mem_wr_en   = we1;
      mem_raddr   = addr1;
      mem_waddr   = addr1;
      mem_data_in = wdata1;
    end
  end

  assign rdata = mem_data_out;

  // rvalid tags come from the access cycle, so a read issued just before a
  // handover still returns to its own port.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state    <= IDLE;
      prio     <= 1'b0;
      burst_ct <= '0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
    end else begin
      state    <= state_nxt;
      prio     <= prio_nxt;
      burst_ct <= burst_ct_nxt;
      gnt0     <= (state_nxt == GNT0);
      gnt1     <= (state_nxt == GNT1);
      rvalid0  <= acc0 & ~we0;
      rvalid1  <= acc1 & ~we1;
    end
  end

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Scoreboard bench for dm_access_arbiter: directed port scripts, expected grant
// runs / reads / writes queued up front and checked by a negedge monitor.
`timescale 1ns/1ps
module tb_dm_access_arbiter;
  import dm_arb_pkg::*;

  typedef struct { int n; logic we; logic [7:0] a0; logic [7:0] d0; logic lk; } cmd_t;
  typedef struct { int port; int acc; } run_t;
  typedef struct { int port; logic [7:0] addr; logic [7:0] data; int gnt_chk; } rd_t;
  typedef struct { logic [7:0] addr; logic [7:0] data; } wr_t;

  logic       clk;
  logic       init_n = 1'b1;
  logic       sel_cap = 1'b0;

  logic       gnt0, gnt1, rvalid0, rvalid1, mem_wr_en;
  logic [7:0] rdata, mem_raddr, mem_waddr, mem_data_in, mem_data_out;
  logic       cgnt0, cgnt1, crvalid0, crvalid1, cmem_wr_en;
  logic [7:0] crdata, cmem_raddr, cmem_waddr, cmem_data_in;
  logic [1:0] gsel;

  int checks = 0, passes = 0, fails = 0;
  int acc_total = 0, both_ct = 0;

  cmd_t cq0[$], cq1[$];
  run_t run_q[$];
  rd_t  rd_q[$];
  wr_t  wr_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Port drivers: raise req, hold it until the requested number of accesses
  // has been granted, stepping the address/data by one per access.
  for (genvar p = 0; p < 2; p++) begin : g_port
    logic       req, lock, we;
    logic [7:0] addr, wdata;
    int         done;
    initial begin
      cmd_t c;
      int   k;
      logic got;
      req = 0; lock = 0; we = 0; addr = '0; wdata = '0; done = 0;
      forever begin
        @(posedge clk); #1;
        got = 1'b0;
        if (p == 0) begin
          if (cq0.size() != 0) begin c = cq0.pop_front(); got = 1'b1; end
        end else begin
          if (cq1.size() != 0) begin c = cq1.pop_front(); got = 1'b1; end
        end
        if (got) begin
          req = 1; lock = c.lk; we = c.we; addr = c.a0; wdata = c.d0; k = 0;
          if (c.n == 0) begin
            @(posedge clk); #1;
            req = 0; lock = 0;
          end
          while (k < c.n) begin
            @(negedge clk);
            if (gsel[p]) k++;
            @(posedge clk); #1;
            if (k == c.n) begin req = 0; lock = 0; we = 0; end
            else begin addr = c.a0 + 8'(k); wdata = c.d0 + 8'(k); end
          end
          done++;
        end
      end
    end
  end

  assign gsel = sel_cap ? {cgnt1, cgnt0} : {gnt1, gnt0};

  dm_access_arbiter dut (
    .clk(clk), .init_n(init_n),
    .req0(g_port[0].req & ~sel_cap), .req1(g_port[1].req & ~sel_cap),
    .lock0(g_port[0].lock), .lock1(g_port[1].lock),
    .we0(g_port[0].we), .we1(g_port[1].we),
    .addr0(g_port[0].addr), .addr1(g_port[1].addr),
    .wdata0(g_port[0].wdata), .wdata1(g_port[1].wdata),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .mem_wr_en(mem_wr_en), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  dm_access_arbiter #(.MAX_BURST(4)) dut_cap (
    .clk(clk), .init_n(init_n),
    .req0(g_port[0].req & sel_cap), .req1(g_port[1].req & sel_cap),
    .lock0(g_port[0].lock), .lock1(g_port[1].lock),
    .we0(g_port[0].we), .we1(g_port[1].we),
    .addr0(g_port[0].addr), .addr1(g_port[1].addr),
    .wdata0(g_port[0].wdata), .wdata1(g_port[1].wdata),
    .gnt0(cgnt0), .gnt1(cgnt1), .rvalid0(crvalid0), .rvalid1(crvalid1), .rdata(crdata),
    .mem_wr_en(cmem_wr_en), .mem_raddr(cmem_raddr), .mem_waddr(cmem_waddr),
    .mem_data_in(cmem_data_in), .mem_data_out(8'h00)
  );

  // dat_mem stand-in: registered read, contents preset to addr ^ 5A
  logic [7:0] tb_mem [256];
  initial begin
    for (int i = 0; i < 256; i++) tb_mem[i] = 8'(i) ^ 8'h5A;
    forever begin
      @(posedge clk);
      if (mem_wr_en) tb_mem[mem_waddr] <= mem_data_in;
      mem_data_out <= tb_mem[mem_raddr];
    end
  end

  function automatic int port_of(input logic [1:0] g);
    return (g == 2'b01) ? 0 : (g == 2'b10) ? 1 : 3;
  endfunction

  // Monitor: grant runs (port, accesses), read returns, memory writes
  initial begin
    logic [1:0] cur, gv;
    int         acc;
    logic [7:0] pend;
    run_t r; rd_t e; wr_t w;
    cur = 2'b00; acc = 0; pend = '0;
    forever begin
      @(negedge clk);
      gv = gsel;
      if (gv == 2'b11) both_ct++;
      if (gv != cur) begin
        if (cur != 2'b00) begin
          chk("run_expected", 32'(run_q.size() != 0), 1);
          if (run_q.size() != 0) begin
            r = run_q.pop_front();
            chk("run_port", port_of(cur), r.port);
            chk("run_accesses", acc, r.acc);
          end
        end
        cur = gv; acc = 0;
      end
      if ((gv == 2'b01 && g_port[0].req) || (gv == 2'b10 && g_port[1].req)) begin
        acc++; acc_total++;
      end
      if (rvalid0 || rvalid1) begin
        chk("rd_expected", 32'(rd_q.size() != 0), 1);
        if (rd_q.size() != 0) begin
          e = rd_q.pop_front();
          chk("rd_port", {rvalid1, rvalid0}, (e.port == 0) ? 2'b01 : 2'b10);
          chk("rd_addr", pend, e.addr);
          chk("rd_data", rdata, e.data);
          if (e.gnt_chk >= 0) chk("rd_gnt_now", {gnt1, gnt0}, (e.gnt_chk == 0) ? 2'b01 : 2'b10);
        end
      end
      if (((gnt0 && g_port[0].req) || (gnt1 && g_port[1].req)) && !sel_cap && !mem_wr_en)
        pend = mem_raddr;
      if (mem_wr_en) begin
        chk("wr_expected", 32'(wr_q.size() != 0), 1);
        if (wr_q.size() != 0) begin
          w = wr_q.pop_front();
          chk("wr_addr", mem_waddr, w.addr);
          chk("wr_data", mem_data_in, w.data);
        end
      end
    end
  end

  int t0 = 0, t1 = 0;

  task automatic wait_done();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = (g_port[0].done >= t0) && (g_port[1].done >= t1);
    end
    chk("scripts_done", 32'(ok), 1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int base;
    #1 init_n = 1'b0;
    #11;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_rvalid", {rvalid1, rvalid0}, 0);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_waddr", mem_waddr, 0);
    chk("rst_data_in", mem_data_in, 0);
    chk("rst_cap_gnt", {cgnt1, cgnt0}, 0);
    @(negedge clk); init_n = 1'b1;
    repeat (2) @(negedge clk);

    // solo read by port 1
    run_q.push_back('{1, 1});
    rd_q.push_back('{1, MSG_BASE, 8'h1A, -1});
    cq1.push_back('{1, 1'b0, MSG_BASE, 8'h00, 1'b0});
    t1++; wait_done();

    // contention without lock: one access each, alternating from port 0
    for (int i = 0; i < 3; i++) begin
      run_q.push_back('{0, 1}); run_q.push_back('{1, 1});
      wr_q.push_back('{8'd80 + 8'(i), 8'hA0 + 8'(i)});
      wr_q.push_back('{8'd90 + 8'(i), 8'hB0 + 8'(i)});
    end
    cq0.push_back('{3, 1'b1, 8'd80, 8'hA0, 1'b0});
    cq1.push_back('{3, 1'b1, 8'd90, 8'hB0, 1'b0});
    t0++; t1++; wait_done();

    // locked burst of 5 writes with port 1 pending, then port 1 reads back
    run_q.push_back('{0, 5}); run_q.push_back('{1, 1});
    for (int i = 0; i < 5; i++) wr_q.push_back('{MSG_BASE + 8'(i), 8'hC0 + 8'(i)});
    rd_q.push_back('{1, 8'd66, 8'hC2, -1});
    cq0.push_back('{5, 1'b1, MSG_BASE, 8'hC0, 1'b1});
    @(posedge clk); #2;
    cq1.push_back('{1, 1'b0, 8'd66, 8'h00, 1'b0});
    t0++; t1++; wait_done();

    // port 0 read just before handover returns on rvalid0 while gnt1 is high
    run_q.push_back('{0, 1}); run_q.push_back('{1, 1});
    rd_q.push_back('{0, 8'd70, 8'h1C, 1});
    wr_q.push_back('{8'd71, 8'h77});
    cq0.push_back('{1, 1'b0, 8'd70, 8'h00, 1'b0});
    cq1.push_back('{1, 1'b1, 8'd71, 8'h77, 1'b0});
    t0++; t1++; wait_done();

    // request withdrawn in the cycle the grant rises: grant with no access
    run_q.push_back('{0, 0});
    cq0.push_back('{0, 1'b1, 8'd99, 8'hEE, 1'b0});
    t0++; wait_done();

    // async reset in the middle of a locked read burst drops the in-flight read
    run_q.push_back('{0, 2}); run_q.push_back('{0, 1});
    rd_q.push_back('{0, MSG_BASE, 8'hC0, -1});
    rd_q.push_back('{0, 8'd66, 8'hC2, -1});
    base = acc_total;
    cq0.push_back('{3, 1'b0, MSG_BASE, 8'h00, 1'b1});
    for (int i = 0; i < 100 && acc_total < base + 2; i++) begin
      @(negedge clk); #1;
    end
    chk("burst_reached", 32'(acc_total >= base + 2), 1);
    init_n = 1'b0; #1;
    chk("midrst_gnt", {gnt1, gnt0}, 0);
    chk("midrst_rvalid", {rvalid1, rvalid0}, 0);
    chk("midrst_wr_en", mem_wr_en, 0);
    chk("midrst_raddr", mem_raddr, 0);
    @(negedge clk); @(negedge clk); init_n = 1'b1;
    t0++; wait_done();

    // starvation cap on the MAX_BURST=4 instance
    sel_cap = 1'b1;
    @(negedge clk);
    run_q.push_back('{0, 4}); run_q.push_back('{1, 1});
    run_q.push_back('{0, 2}); run_q.push_back('{1, 1});
    cq0.push_back('{6, 1'b1, 8'h20, 8'h00, 1'b1});
    @(posedge clk); #2;
    cq1.push_back('{2, 1'b1, 8'h30, 8'h00, 1'b0});
    t0++; t1++; wait_done();
    sel_cap = 1'b0;

    repeat (3) @(negedge clk);
    chk("runs_left", run_q.size(), 0);
    chk("reads_left", rd_q.size(), 0);
    chk("writes_left", wr_q.size(), 0);
    chk("both_granted_cycles", both_ct, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
